// File: rtl/led_pkg.sv
// Shared types for the LED driver: channel mode encoding and its width.
package led_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 3'd0,
        MODE_ON      = 3'd1,
        MODE_BLINK   = 3'd2,
        MODE_PWM     = 3'd3,
        MODE_BREATHE = 3'd4
    } led_mode_e;

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode/duty/period registers, blink and breathe state, registered drive.
// BREATHE mode and its level/direction registers exist only when LED_BREATHE_EN is defined.
module led_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int PERIOD_BITS = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic [PWM_BITS-1:0]    pwm_cnt,
    input  logic                   wr,
    input  logic [MODE_W-1:0]      cfg_mode,
    input  logic [PWM_BITS-1:0]    cfg_duty,
    input  logic [PERIOD_BITS-1:0] cfg_period,
    output logic                   led
);

    led_mode_e              mode;
    led_mode_e              wr_mode;
    logic [PWM_BITS-1:0]    duty;
    logic [PERIOD_BITS-1:0] period;
    logic [PERIOD_BITS-1:0] period_m1;
    logic [PERIOD_BITS-1:0] blink_cnt;
    logic                   phase;
    logic                   led_next;

    // Reserved encodings (and BREATHE when not built in) collapse to OFF at write time.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_mode = MODE_OFF;
        case (cfg_mode)
            MODE_ON:      wr_mode = MODE_ON;
            MODE_BLINK:   wr_mode = MODE_BLINK;
            MODE_PWM:     wr_mode = MODE_PWM;
`ifdef LED_BREATHE_EN
            MODE_BREATHE: wr_mode = MODE_BREATHE;
`endif
            default:      wr_mode = MODE_OFF;
        endcase
    end

    // A half-period of 0 behaves as 1: toggle on every tick.
    assign period_m1 = (period == '0) ? '0 : period - PERIOD_BITS'(1);

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode      <= MODE_OFF;
            duty      <= '0;
            period    <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (wr) begin
            mode      <= wr_mode;
            duty      <= cfg_duty;
            period    <= cfg_period;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (tick && mode == MODE_BLINK) begin
            if (blink_cnt >= period_m1) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + PERIOD_BITS'(1);
            end
        end
    end

`ifdef LED_BREATHE_EN
    logic [PWM_BITS-1:0] level;
    logic                dir_down;

    // The level holds at an endpoint for the step on which the direction flips.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level    <= '0;
            dir_down <= 1'b0;
        end else if (wr) begin
            level    <= '0;
            dir_down <= 1'b0;
        end else if (tick && mode == MODE_BREATHE) begin
            if (!dir_down) begin
                if (level == '1) dir_down <= 1'b1;
                else             level    <= level + PWM_BITS'(1);
            end else begin
                if (level == '0) dir_down <= 1'b0;
                else             level    <= level - PWM_BITS'(1);
            end
        end
    end
`endif

    always_comb begin
        led_next = 1'b0;
        case (mode)
            MODE_ON:      led_next = 1'b1;
            MODE_BLINK:   led_next = phase;
            MODE_PWM:     led_next = (pwm_cnt < duty);
`ifdef LED_BREATHE_EN
            MODE_BREATHE: led_next = (pwm_cnt < level);
`endif
            default:      led_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) led <= 1'b0;
        else     led <= led_next;
    end

endmodule

// File: rtl/led_driver.sv
// Multi-channel LED driver: shared prescaler tick, shared PWM counter, config handshake.
// Optional BREATHE mode is enabled by defining LED_BREATHE_EN.
module led_driver
    import led_pkg::*;
#(
    parameter int NUM_LED     = 4,
    parameter int CLK_HZ      = 100_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int PWM_BITS    = 8,
    parameter int PERIOD_BITS = 12,
    localparam int CHAN_W     = (NUM_LED > 1) ? $clog2(NUM_LED) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CHAN_W-1:0]      cfg_chan,
    input  logic [MODE_W-1:0]      cfg_mode,
    input  logic [PWM_BITS-1:0]    cfg_duty,
    input  logic [PERIOD_BITS-1:0] cfg_period,
    output logic [NUM_LED-1:0]     led,
    output logic                   tick
);

    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int PRESC_W = (DIV >= 2) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_div_check
        $error("led_driver: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (NUM_LED < 1 || NUM_LED > 16) begin : g_num_led_check
        $error("led_driver: NUM_LED must be in 1..16");
    end

    logic [PRESC_W-1:0]  presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                accept;

    assign tick   = (presc == PRESC_W'(DIV - 1));
    assign accept = cfg_valid && cfg_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            pwm_cnt   <= '0;
            cfg_ready <= 1'b0;
        end else begin
            presc     <= tick ? '0 : presc + PRESC_W'(1);
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
            cfg_ready <= 1'b1;
        end
    end

    // Out-of-range channel numbers match no instance, so the write completes with no effect.
    for (genvar gi = 0; gi < NUM_LED; gi++) begin : g_chan
        led_channel #(
            .PWM_BITS    (PWM_BITS),
            .PERIOD_BITS (PERIOD_BITS)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .pwm_cnt    (pwm_cnt),
            .wr         (accept && (cfg_chan == CHAN_W'(gi))),
            .cfg_mode   (cfg_mode),
            .cfg_duty   (cfg_duty),
            .cfg_period (cfg_period),
            .led        (led[gi])
        );
    end

endmodule

// File: tb/tb_led_driver.sv
// Self-checking bench for led_driver: table-driven ON/OFF vectors plus hand-written
// blink, PWM, collision, reset and breathe sequences (breathe depends on LED_BREATHE_EN).
module tb_led_driver;

    localparam int NUM_LED     = 5;
    localparam int CLK_HZ      = 100;
    localparam int TICK_HZ     = 10;
    localparam int DIV         = 10;
    localparam int PWM_BITS    = 8;
    localparam int PERIOD_BITS = 12;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cfg_valid = 1'b0;
    logic                   cfg_ready;
    logic [2:0]             cfg_chan = '0;
    logic [2:0]             cfg_mode = '0;
    logic [PWM_BITS-1:0]    cfg_duty = '0;
    logic [PERIOD_BITS-1:0] cfg_period = '0;
    logic [NUM_LED-1:0]     led;
    logic                   tick;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    led_driver #(
        .NUM_LED     (NUM_LED),
        .CLK_HZ      (CLK_HZ),
        .TICK_HZ     (TICK_HZ),
        .PWM_BITS    (PWM_BITS),
        .PERIOD_BITS (PERIOD_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_mode   (cfg_mode),
        .cfg_duty   (cfg_duty),
        .cfg_period (cfg_period),
        .led        (led),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    // Edges since reset release: the prescaler is cyc % DIV, the PWM counter cyc % 256.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        logic [2:0]         chan;
        logic [2:0]         mode;
        logic [NUM_LED-1:0] exp_led;
        string              name;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_cfg(input logic [2:0] chan, input logic [2:0] mode,
                             input logic [PWM_BITS-1:0] duty, input logic [PERIOD_BITS-1:0] period);
        cfg_valid  = 1'b1;
        cfg_chan   = chan;
        cfg_mode   = mode;
        cfg_duty   = duty;
        cfg_period = period;
        check("cfg_ready_at_write", 32'(cfg_ready), 32'd1);
        step(1);
        cfg_valid  = 1'b0;
    endtask

    task automatic wait_toggle(input int idx, input int budget, output int n, output logic ok);
        logic prev;
        prev = led[idx];
        n    = 0;
        ok   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            n++;
            if (led[idx] !== prev) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic blink_intervals(input string name, input int exp_n);
        int   n;
        logic ok;
        // Two toggles are discarded: the write may clear phase before the tick cadence settles.
        for (int k = 0; k < 2; k++) begin
            wait_toggle(0, 100, n, ok);
            check({name, "_settle"}, 32'(ok), 32'd1);
        end
        for (int k = 0; k < 2; k++) begin
            wait_toggle(0, 100, n, ok);
            check({name, "_interval"}, 32'(n), 32'(exp_n));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int               errs;
        int               lit;
        logic [NUM_LED-1:0] prev_led;

        vecs[0] = '{3'd2, 3'd1, 5'b00100, "on_c2"};
        vecs[1] = '{3'd0, 3'd1, 5'b00101, "on_c0"};
        vecs[2] = '{3'd7, 3'd1, 5'b00101, "on_out_of_range"};
        vecs[3] = '{3'd4, 3'd5, 5'b00101, "reserved5_c4"};
        vecs[4] = '{3'd4, 3'd1, 5'b10101, "on_c4"};
        vecs[5] = '{3'd0, 3'd7, 5'b10100, "reserved7_c0"};
        vecs[6] = '{3'd2, 3'd0, 5'b10000, "off_c2"};
        vecs[7] = '{3'd6, 3'd0, 5'b10000, "off_out_of_range"};
        vecs[8] = '{3'd4, 3'd0, 5'b00000, "off_c4"};

        // Reset held for five edges, then released between edges.
        rst = 1'b1;
        step(5);
        check("reset_led", 32'(led), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_ready", 32'(cfg_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_before_first_edge", 32'(cfg_ready), 32'd0);
        step(1);
        check("ready_after_release", 32'(cfg_ready), 32'd1);
        check("led_after_release", 32'(led), 32'd0);

        errs = 0;
        for (int i = 0; i < 100; i++) begin
            if (tick !== ((cyc % DIV) == DIV - 1)) errs++;
            step(1);
        end
        check("tick_pattern", 32'(errs), 32'd0);

        prev_led = '0;
        for (int i = 0; i < 9; i++) begin
            write_cfg(vecs[i].chan, vecs[i].mode, 8'd0, 12'd0);
            check({vecs[i].name, "_latency"}, 32'(led), 32'(prev_led));
            step(1);
            check(vecs[i].name, 32'(led), 32'(vecs[i].exp_led));
            prev_led = vecs[i].exp_led;
        end

        write_cfg(3'd0, 3'd2, 8'd0, 12'd3);
        blink_intervals("blink_p3", 30);
        write_cfg(3'd0, 3'd2, 8'd0, 12'd0);
        blink_intervals("blink_p0", 10);

        write_cfg(3'd1, 3'd3, 8'd64, 12'd0);
        step(2);
        lit = 0;
        for (int i = 0; i < 256; i++) begin
            lit += int'(led[1]);
            step(1);
        end
        check("pwm_duty64", 32'(lit), 32'd64);

        write_cfg(3'd1, 3'd3, 8'd0, 12'd0);
        step(2);
        lit = 0;
        for (int i = 0; i < 256; i++) begin
            lit += int'(led[1]);
            step(1);
        end
        check("pwm_duty0", 32'(lit), 32'd0);

        write_cfg(3'd1, 3'd3, 8'd255, 12'd0);
        step(2);
        lit = 0;
        for (int i = 0; i < 256; i++) begin
            lit += int'(led[1]);
            step(1);
        end
        check("pwm_duty255", 32'(lit), 32'd255);

        // Write lands on the tick edge: the write wins, so phase stays 0 until the next tick.
        for (int i = 0; i < DIV && (cyc % DIV) != DIV - 1; i++) step(1);
        check("collision_align", 32'(cyc % DIV), 32'(DIV - 1));
        write_cfg(3'd0, 3'd2, 8'd0, 12'd1);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (led[0] !== 1'b0) errs++;
        end
        check("collision_no_tick_applied", 32'(errs), 32'd0);
        step(1);
        check("collision_next_tick_toggles", 32'(led[0]), 32'd1);

        // Asynchronous reset mid-blink while led[0] is lit.
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_led", 32'(led), 32'd0);
        check("async_reset_ready", 32'(cfg_ready), 32'd0);
        check("async_reset_tick", 32'(tick), 32'd0);
        step(1);
        rst = 1'b0;
        step(1);
        check("ready_after_mid_reset", 32'(cfg_ready), 32'd1);
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (led !== '0) errs++;
        end
        check("channels_off_after_reset", 32'(errs), 32'd0);

        write_cfg(3'd3, 3'd4, 8'd0, 12'd0);
`ifdef LED_BREATHE_EN
        begin
            int   lvl;
            logic up;
            logic exp_bit;
            lvl  = 0;
            up   = 1'b1;
            errs = 0;
            for (int i = 0; i < 5300; i++) begin
                exp_bit = ((cyc % 256) < lvl);
                if ((cyc % DIV) == DIV - 1) begin
                    if (up) begin
                        if (lvl == 255) up = 1'b0;
                        else            lvl++;
                    end else begin
                        if (lvl == 0) up = 1'b1;
                        else          lvl--;
                    end
                end
                step(1);
                if (led[3] !== exp_bit) errs++;
            end
            check("breathe_trace", 32'(errs), 32'd0);
        end
`else
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (led[3] !== 1'b0) errs++;
        end
        check("mode4_disabled_off", 32'(errs), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
